gpr_access_ctrl: RTL and testbench
==================================

// Module: gpr_access_ctrl
// PURPOSE
// Shares the general purpose register file between the CPU pipeline and a debug/host port.
// Steals idle read-port-1 or write-port cycles for debug reads and writes.
// Forces a pipeline stall when a debug request starves, and runs a soft clear-all sequence.
// Sits between the decode/writeback stages and gpr; read port 0 always belongs to the pipeline.
// PARAMETERS
// ADDR_W        5   register address width (matches RegAddrBus)
// DATA_W        32  register data width (matches WordDataBus)
// REG_NUM       32  number of registers to clear
// STARVE_LIMIT  8   waiting cycles before a forced stall (>=1)
// PORTS
// clk            in   1       single clock; all state updates on posedge
// reset          in   1       synchronous, active-low reset
// pipe_rd_addr_0 in   ADDR_W  pipeline read address, port 0
// pipe_rd_addr_1 in   ADDR_W  pipeline read address, port 1
// pipe_rd1_used  in   1       pipeline needs read port 1 this cycle
// pipe_we_       in   1       pipeline write enable, active low
// pipe_wr_addr   in   ADDR_W  pipeline write address
// pipe_wr_data   in   DATA_W  pipeline write data
// pipe_stall     out  1       registered; pipeline holds and releases both shared ports
// dbg_req        in   1       debug request, held high until dbg_ack
// dbg_rw         in   1       1 = write, 0 = read; stable while dbg_req is high
// dbg_addr       in   ADDR_W  debug register address; stable while dbg_req is high
// dbg_wdata      in   DATA_W  debug write data; stable while dbg_req is high
// dbg_ack        out  1       one-cycle completion pulse
// dbg_rdata      out  DATA_W  read result; valid with dbg_ack and held until the next read
// clr_req        in   1       one-cycle pulse that starts clear-all
// clr_busy       out  1       clear sequence in progress
// gpr_rd_addr_0  out  ADDR_W  to gpr; always equals pipe_rd_addr_0
// gpr_rd_addr_1  out  ADDR_W  to gpr port 1 address
// gpr_rd_data_1  in   DATA_W  from gpr port 1 data (includes gpr write bypass)
// gpr_we_        out  1       to gpr write enable, active low
// gpr_wr_addr    out  ADDR_W  to gpr write address
// gpr_wr_data    out  DATA_W  to gpr write data
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - state=IDLE; pipe_stall, dbg_ack and clr_busy = 0; dbg_rdata = 0; starve/clear counters = 0.
//   - Reset during CLEAR aborts the sequence; registers are left partially cleared.
// - FSM states:
//   - IDLE: waiting for a request.
//   - WAIT: debug request pending, no free slot yet.
//   - ACK: dbg_ack=1 for exactly one cycle, then IDLE; starve counter cleared.
//   - CLEAR: clear-all in progress.
// - Slot test (combinational, in IDLE or WAIT with dbg_req=1 and dbg_ack=0):
//   - Write slot exists when pipe_we_=1; read slot exists when pipe_rd1_used=0.
// - Grant: the slot exists -> the gpr ports are driven from dbg_* in that same cycle -> next state ACK.
//   - A read loads dbg_rdata from gpr_rd_data_1 at that edge, giving one-cycle latency.
// - No slot: go to (or stay in) WAIT and increment the saturating starve counter.
//   - When the counter reaches STARVE_LIMIT, pipe_stall=1 from the next cycle.
//   - During a stall the pipeline drives pipe_we_=1 and pipe_rd1_used=0, so the grant follows.
//   - pipe_stall drops in ACK.
// - dbg_req is ignored while dbg_ack=1. A dbg_req still high after ACK is taken as a new transaction.
// - A debug write to the address the pipeline reads on port 0 in the same cycle returns the new value
//   through the gpr bypass. This is the intended behaviour.
// - CLEAR entry and sequencing:
//   - Entered from IDLE only; clr_req outside IDLE is dropped.
//   - clr_req beats dbg_req when both arrive together.
//   - Each cycle: gpr_we_=0, gpr_wr_addr=idx, gpr_wr_data=0; idx counts 0..REG_NUM-1, then IDLE.
//   - pipe_stall=1 and clr_busy=1 for exactly REG_NUM cycles.
// - Pending debug requests during CLEAR:
//   - They wait and do not advance the starve counter.
//   - They are served by the normal slot rules once back in IDLE.
// - A pipeline write during CLEAR violates the contract: it is dropped and the clear write wins.
// - Default mux when no grant and not in CLEAR: gpr ports are driven straight from pipe_*.
// STRUCTURE
// - Shared header: FSM state encodings, ENABLE_/DISABLE_ and RESET_ENABLE defines.
//   RegAddrBus, WordDataBus and REG_NUM come from the existing global headers.
// - One sub-module, gpr_clear_seq: index counter with start/busy/last outputs.
// - FSM, starve counter and port muxes stay in this module.
// TESTING
// 1. Write slot: dbg write r5=0x1234_5678 with pipe_we_=1 -> gpr_we_=0 same cycle; dbg_ack next cycle;
//    read-back returns 0x1234_5678.
// 2. Read slot: dbg read r3 while pipe_rd1_used=0 -> dbg_rdata=r3 with dbg_ack one cycle later;
//    gpr_rd_addr_1 returns to the pipeline address.
// 3. Starvation: pipe_rd1_used=1 held, debug read pending -> pipe_stall rises after 8 wait cycles;
//    grant follows, then ACK, then the stall drops.
// 4. Clear: clr_req with dbg_req in the same cycle -> 32 zero writes to r0..r31 with clr_busy=1;
//    then the debug request completes and every register reads 0.
// 5. Reset at clear idx=10 -> all outputs return to reset values the next cycle;
//    r11..r31 are not written by the controller.

Source files
------------

// File: rtl/gpr_access_ctrl_pkg.sv
// Shared types and constants for the GPR access controller: FSM encodings,
// active-low enable levels, default widths and the slot-availability helper.
package gpr_access_ctrl_pkg;

    localparam int DEF_ADDR_W       = 5;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_REG_NUM      = 32;
    localparam int DEF_STARVE_LIMIT = 8;

    localparam logic ENABLE_      = 1'b0;
    localparam logic DISABLE_     = 1'b1;
    localparam logic RESET_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    // A write steals an idle write port; a read steals an unused read port 1.
    function automatic logic slot_free(input logic rw, input logic pipe_we_n,
                                       input logic pipe_rd1_used);
        logic free_s;
        if (rw) begin
            free_s = (pipe_we_n == DISABLE_);
        end else begin
            free_s = ~pipe_rd1_used;
        end
        return free_s;
    endfunction

endpackage

// File: rtl/gpr_access_ctrl_if.sv
// Debug/host handshake and clear-all control bundle between a host (master)
// and the GPR access controller (slave).
interface gpr_access_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();

    logic              dbg_req;
    logic              dbg_rw;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic              clr_req;
    logic              clr_busy;

    modport master (
        output dbg_req, dbg_rw, dbg_addr, dbg_wdata, clr_req,
        input  dbg_ack, dbg_rdata, clr_busy
    );

    modport slave (
        input  dbg_req, dbg_rw, dbg_addr, dbg_wdata, clr_req,
        output dbg_ack, dbg_rdata, clr_busy
    );

endinterface

// File: rtl/gpr_access_ctrl_clear_seq.sv
// Clear-all index generator: walks idx from 0 to REG_NUM-1 once per start pulse.
module gpr_clear_seq
    import gpr_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int REG_NUM = DEF_REG_NUM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              last,
    output logic [ADDR_W-1:0] idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // Next index and busy flag.
    always_comb begin
        busy_d = busy_q;
        idx_d  = idx_q;
        if (busy_q) begin
            if (idx_q == LAST_IDX) begin
                busy_d = 1'b0;
                idx_d  = {ADDR_W{1'b0}};
            end else begin
                busy_d = 1'b1;
                idx_d  = idx_q + ADDR_W'(1);
            end
        end else if (start) begin
            busy_d = 1'b1;
            idx_d  = {ADDR_W{1'b0}};
        end else begin
            busy_d = 1'b0;
            idx_d  = {ADDR_W{1'b0}};
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            busy_q <= 1'b0;
            idx_q  <= {ADDR_W{1'b0}};
        end else begin
            busy_q <= busy_d;
            idx_q  <= idx_d;
        end
    end

    assign busy = busy_q;
    assign idx  = idx_q;
    assign last = busy_q && (idx_q == LAST_IDX);

endmodule

// File: rtl/gpr_access_ctrl.sv
// Shares the GPR file between the pipeline and a debug host: steals idle
// port-1 / write-port cycles, forces a stall on starvation, and runs clear-all.
module gpr_access_ctrl
    import gpr_access_ctrl_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int REG_NUM      = DEF_REG_NUM,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pipe_rd_addr_0,
    input  logic [ADDR_W-1:0] pipe_rd_addr_1,
    input  logic              pipe_rd1_used,
    input  logic              pipe_we_,
    input  logic [ADDR_W-1:0] pipe_wr_addr,
    input  logic [DATA_W-1:0] pipe_wr_data,
    output logic              pipe_stall,
    gpr_access_ctrl_if.slave  dbg,
    output logic [ADDR_W-1:0] gpr_rd_addr_0,
    output logic [ADDR_W-1:0] gpr_rd_addr_1,
    input  logic [DATA_W-1:0] gpr_rd_data_1,
    output logic              gpr_we_,
    output logic [ADDR_W-1:0] gpr_wr_addr,
    output logic [DATA_W-1:0] gpr_wr_data
);

    localparam int                STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_e              state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                stall_q, stall_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic              dbg_pend_s;
    logic              clr_start_s;
    logic              grant_s;
    logic              seq_busy_s;
    logic              seq_last_s;
    logic [ADDR_W-1:0] seq_idx_s;

    gpr_clear_seq #(
        .ADDR_W  (ADDR_W),
        .REG_NUM (REG_NUM)
    ) u_clear_seq (
        .clk   (clk),
        .reset (reset),
        .start (clr_start_s),
        .busy  (seq_busy_s),
        .last  (seq_last_s),
        .idx   (seq_idx_s)
    );

    // Request qualification; clear-all takes priority over a same-cycle debug request.
    always_comb begin
        dbg_pend_s  = dbg.dbg_req && !ack_q &&
                      ((state_q == ST_IDLE) || (state_q == ST_WAIT));
        clr_start_s = dbg.clr_req && (state_q == ST_IDLE);
        grant_s     = dbg_pend_s && !clr_start_s &&
                      slot_free(dbg.dbg_rw, pipe_we_, pipe_rd1_used);
    end

    // GPR port mux: clear writes, then granted debug access, else the pipeline.
    always_comb begin
        gpr_rd_addr_0 = pipe_rd_addr_0;
        gpr_rd_addr_1 = pipe_rd_addr_1;
        gpr_we_       = pipe_we_;
        gpr_wr_addr   = pipe_wr_addr;
        gpr_wr_data   = pipe_wr_data;
        if (state_q == ST_CLEAR) begin
            gpr_we_     = ENABLE_;
            gpr_wr_addr = seq_idx_s;
            gpr_wr_data = {DATA_W{1'b0}};
        end else if (grant_s) begin
            if (dbg.dbg_rw) begin
                gpr_we_     = ENABLE_;
                gpr_wr_addr = dbg.dbg_addr;
                gpr_wr_data = dbg.dbg_wdata;
            end else begin
                gpr_rd_addr_1 = dbg.dbg_addr;
            end
        end else begin
            gpr_we_ = pipe_we_;
        end
    end

    // FSM next state, starvation counter and registered outputs.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        stall_d  = stall_q;
        ack_d    = 1'b0;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (clr_start_s) begin
                    state_d  = ST_CLEAR;
                    starve_d = {STARVE_W{1'b0}};
                    stall_d  = 1'b1;
                    busy_d   = 1'b1;
                end else if (grant_s) begin
                    state_d  = ST_ACK;
                    starve_d = {STARVE_W{1'b0}};
                    stall_d  = 1'b0;
                    ack_d    = 1'b1;
                    if (!dbg.dbg_rw) begin
                        rdata_d = gpr_rd_data_1;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (dbg_pend_s) begin
                    state_d  = ST_WAIT;
                    starve_d = (starve_q == STARVE_MAX) ? starve_q
                                                        : starve_q + STARVE_W'(1);
                    stall_d  = (starve_d == STARVE_MAX);
                end else begin
                    state_d  = ST_IDLE;
                    starve_d = {STARVE_W{1'b0}};
                    stall_d  = 1'b0;
                end
            end
            ST_ACK: begin
                state_d  = ST_IDLE;
                starve_d = {STARVE_W{1'b0}};
                stall_d  = 1'b0;
            end
            ST_CLEAR: begin
                // Pending debug requests simply wait here; the counter does not move.
                if (seq_last_s || !seq_busy_s) begin
                    state_d = ST_IDLE;
                    stall_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    stall_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                starve_d = {STARVE_W{1'b0}};
                stall_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Controller state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            state_q  <= ST_IDLE;
            starve_q <= {STARVE_W{1'b0}};
            stall_q  <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            rdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
        end
    end

    assign pipe_stall    = stall_q;
    assign dbg.dbg_ack   = ack_q;
    assign dbg.dbg_rdata = rdata_q;
    assign dbg.clr_busy  = busy_q;

endmodule

// File: tb/tb_gpr_access_ctrl.sv
// Directed bench for gpr_access_ctrl with a behavioural register file
// (including write bypass on read port 1) attached to the gpr_* ports.
module tb_gpr_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pipe_rd_addr_0, pipe_rd_addr_1, pipe_wr_addr;
    logic        pipe_rd1_used, pipe_we_;
    logic [31:0] pipe_wr_data;
    logic        pipe_stall;
    logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1, gpr_wr_addr;
    logic [31:0] gpr_rd_data_1, gpr_wr_data;
    logic        gpr_we_;
    logic        preload;
    logic [31:0] regs [32];
    int          total_cnt = 0;
    int          pass_cnt  = 0;

    gpr_access_ctrl_if #(.ADDR_W(5), .DATA_W(32)) dbg_if ();

    gpr_access_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_rd_addr_0 (pipe_rd_addr_0),
        .pipe_rd_addr_1 (pipe_rd_addr_1),
        .pipe_rd1_used  (pipe_rd1_used),
        .pipe_we_       (pipe_we_),
        .pipe_wr_addr   (pipe_wr_addr),
        .pipe_wr_data   (pipe_wr_data),
        .pipe_stall     (pipe_stall),
        .dbg            (dbg_if),
        .gpr_rd_addr_0  (gpr_rd_addr_0),
        .gpr_rd_addr_1  (gpr_rd_addr_1),
        .gpr_rd_data_1  (gpr_rd_data_1),
        .gpr_we_        (gpr_we_),
        .gpr_wr_addr    (gpr_wr_addr),
        .gpr_wr_data    (gpr_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'hDEAD_0000 + 32'(i);
        end else if (gpr_we_ == 1'b0) begin
            regs[gpr_wr_addr] <= gpr_wr_data;
        end
    end

    assign gpr_rd_data_1 = ((gpr_we_ == 1'b0) && (gpr_wr_addr == gpr_rd_addr_1))
                           ? gpr_wr_data : regs[gpr_rd_addr_1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        pipe_we_ = 1'b1;
        dbg_if.dbg_req = 1'b1; dbg_if.dbg_rw = 1'b1;
        dbg_if.dbg_addr = a;   dbg_if.dbg_wdata = d;
        tick();
        chk("wr_ack", 32'(dbg_if.dbg_ack), 32'd1);
        dbg_if.dbg_req = 1'b0;
        tick();
    endtask

    task automatic dbg_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
        pipe_rd1_used = 1'b0;
        dbg_if.dbg_req = 1'b1; dbg_if.dbg_rw = 1'b0; dbg_if.dbg_addr = a;
        tick();
        chk({tag, "_ack"}, 32'(dbg_if.dbg_ack), 32'd1);
        chk(tag, dbg_if.dbg_rdata, exp);
        dbg_if.dbg_req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0; preload = 1'b1;
        pipe_rd_addr_0 = 5'd1; pipe_rd_addr_1 = 5'd2; pipe_rd1_used = 1'b0;
        pipe_we_ = 1'b1; pipe_wr_addr = 5'd0; pipe_wr_data = 32'h0;
        dbg_if.dbg_req = 1'b0; dbg_if.dbg_rw = 1'b0; dbg_if.dbg_addr = 5'd0;
        dbg_if.dbg_wdata = 32'h0; dbg_if.clr_req = 1'b0;
        tick(); tick();
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        chk("rst_ack", 32'(dbg_if.dbg_ack), 32'd0);
        chk("rst_busy", 32'(dbg_if.clr_busy), 32'd0);
        chk("rst_rdata", dbg_if.dbg_rdata, 32'd0);
        preload = 1'b0; reset = 1'b1;
        tick();

        // Write slot: pipeline not writing, read port 1 busy.
        pipe_rd1_used = 1'b1;
        dbg_if.dbg_req = 1'b1; dbg_if.dbg_rw = 1'b1;
        dbg_if.dbg_addr = 5'd5; dbg_if.dbg_wdata = 32'h1234_5678;
        #1;
        chk("t1_we", 32'(gpr_we_), 32'd0);
        chk("t1_waddr", 32'(gpr_wr_addr), 32'd5);
        chk("t1_wdata", gpr_wr_data, 32'h1234_5678);
        chk("t1_rd0", 32'(gpr_rd_addr_0), 32'd1);
        tick();
        chk("t1_ack", 32'(dbg_if.dbg_ack), 32'd1);
        dbg_if.dbg_req = 1'b0;
        #1;
        chk("t1_we_back", 32'(gpr_we_), 32'd1);
        tick();
        chk("t1_ack_pulse", 32'(dbg_if.dbg_ack), 32'd0);
        dbg_read("t1_readback", 5'd5, 32'h1234_5678);

        // Read slot while the pipeline writes another register.
        pipe_we_ = 1'b0; pipe_wr_addr = 5'd3; pipe_wr_data = 32'hCAFE_0003;
        tick();
        pipe_wr_addr = 5'd7; pipe_wr_data = 32'h0000_0077; pipe_rd1_used = 1'b0;
        dbg_if.dbg_req = 1'b1; dbg_if.dbg_rw = 1'b0; dbg_if.dbg_addr = 5'd3;
        #1;
        chk("t2_rdaddr", 32'(gpr_rd_addr_1), 32'd3);
        chk("t2_pipe_waddr", 32'(gpr_wr_addr), 32'd7);
        tick();
        chk("t2_ack", 32'(dbg_if.dbg_ack), 32'd1);
        chk("t2_rdata", dbg_if.dbg_rdata, 32'hCAFE_0003);
        dbg_if.dbg_req = 1'b0; pipe_we_ = 1'b1;
        #1;
        chk("t2_rdaddr_back", 32'(gpr_rd_addr_1), 32'd2);
        tick();

        // Starvation: port 1 busy until the forced stall.
        pipe_rd1_used = 1'b1;
        dbg_if.dbg_req = 1'b1; dbg_if.dbg_rw = 1'b0; dbg_if.dbg_addr = 5'd7;
        for (int i = 0; i < 7; i++) tick();
        chk("t3_no_stall_7", 32'(pipe_stall), 32'd0);
        tick();
        chk("t3_stall_8", 32'(pipe_stall), 32'd1);
        chk("t3_no_ack", 32'(dbg_if.dbg_ack), 32'd0);
        pipe_rd1_used = 1'b0;
        #1;
        chk("t3_grant_addr", 32'(gpr_rd_addr_1), 32'd7);
        tick();
        chk("t3_ack", 32'(dbg_if.dbg_ack), 32'd1);
        chk("t3_stall_drop", 32'(pipe_stall), 32'd0);
        chk("t3_rdata", dbg_if.dbg_rdata, 32'h0000_0077);
        dbg_if.dbg_req = 1'b0;
        tick();

        // Clear-all beats a same-cycle debug read; one illegal pipeline write dropped.
        dbg_if.clr_req = 1'b1;
        dbg_if.dbg_req = 1'b1; dbg_if.dbg_rw = 1'b0; dbg_if.dbg_addr = 5'd5;
        #1;
        chk("t4_no_grant", 32'(gpr_rd_addr_1), 32'd2);
        tick();
        dbg_if.clr_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 4) begin
                pipe_we_ = 1'b0; pipe_wr_addr = 5'd20; pipe_wr_data = 32'hFFFF_FFFF;
            end else begin
                pipe_we_ = 1'b1;
            end
            #1;
            chk("t4_busy", 32'(dbg_if.clr_busy), 32'd1);
            chk("t4_stall", 32'(pipe_stall), 32'd1);
            chk("t4_we", 32'(gpr_we_), 32'd0);
            chk("t4_idx", 32'(gpr_wr_addr), 32'(i));
            chk("t4_zero", gpr_wr_data, 32'd0);
            tick();
        end
        pipe_we_ = 1'b1;
        chk("t4_busy_end", 32'(dbg_if.clr_busy), 32'd0);
        chk("t4_stall_end", 32'(pipe_stall), 32'd0);
        chk("t4_pend_grant", 32'(gpr_rd_addr_1), 32'd5);
        tick();
        chk("t4_pend_ack", 32'(dbg_if.dbg_ack), 32'd1);
        chk("t4_pend_rdata", dbg_if.dbg_rdata, 32'd0);
        dbg_if.dbg_req = 1'b0;
        tick();
        for (int r = 0; r < 32; r++) dbg_read("t4_cleared", 5'(r), 32'd0);

        // Reset while the clear index is 10.
        dbg_write(5'd11, 32'h1111_0011);
        dbg_write(5'd20, 32'hA5A5_0014);
        dbg_read("t5_pre", 5'd20, 32'hA5A5_0014);
        pipe_wr_addr = 5'd9;
        dbg_if.clr_req = 1'b1;
        tick();
        dbg_if.clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_idx10", 32'(gpr_wr_addr), 32'd10);
        reset = 1'b0;
        tick();
        chk("t5_stall", 32'(pipe_stall), 32'd0);
        chk("t5_ack", 32'(dbg_if.dbg_ack), 32'd0);
        chk("t5_busy", 32'(dbg_if.clr_busy), 32'd0);
        chk("t5_rdata", dbg_if.dbg_rdata, 32'd0);
        chk("t5_we", 32'(gpr_we_), 32'd1);
        chk("t5_waddr", 32'(gpr_wr_addr), 32'd9);
        reset = 1'b1;
        tick();
        chk("t5_still_idle", 32'(gpr_we_), 32'd1);
        dbg_read("t5_r10", 5'd10, 32'd0);
        dbg_read("t5_r11", 5'd11, 32'h1111_0011);
        dbg_read("t5_r20", 5'd20, 32'hA5A5_0014);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
